// File: rtl/pipe_sel_mux.sv
// N-way channel select with registered output and a 2-entry skid buffer
// on a valid/ready handshake; sits between ID and EX for destination/operand choice.
module pipe_sel_mux #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_ONE   = 2'd1;
    localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

    logic [ST_W-1:0]  state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] cap_data;
    logic             sel_bad;
    logic             accept;
    logic             pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Channel mux; an out-of-range select captures zero and flags an error.
    always_comb begin
        cap_data = '0;
        sel_bad  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                cap_data = in_data[k*WIDTH +: WIDTH];
                sel_bad  = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush squashes everything held, unknown encodings recover to EMPTY.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (accept && !pop)      state_d = ST_FULL;
                    else if (!accept && pop) state_d = ST_EMPTY;
                end
                ST_FULL: begin
                    if (pop) state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Datapath and handshake outputs; ready/valid derive from next state so they are exact on entry.
    always_comb begin
        head_d      = head_q;
        skid_d      = skid_q;
        sel_err_d   = 1'b0;
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        if (!flush) begin
            sel_err_d = accept & sel_bad;
            case (state_q)
                ST_EMPTY: begin
                    if (accept) head_d = cap_data;
                end
                ST_ONE: begin
                    if (accept && pop)       head_d = cap_data;
                    else if (accept && !pop) skid_d = cap_data;
                end
                ST_FULL: begin
                    if (pop) head_d = skid_q;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed vector bench for pipe_sel_mux: one vector per clock, outputs
// sampled 1 time unit after the rising edge that the vector's inputs fed.
module tb_pipe_sel_mux;

    localparam int unsigned WIDTH  = 5;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned SEL_W  = 2;

    logic                    clk;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    pipe_sel_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        vld;
        logic [1:0]  sel;
        logic        flush;
        logic        ordy;
        logic [14:0] data;
        logic        e_ov;
        logic [4:0]  e_od;
        logic        e_ir;
        logic        e_se;
        logic        chk_od;
    } vec_t;

    localparam logic [14:0] D = {5'd31, 5'd15, 5'd7};

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(input string nm, input logic r, input logic v,
                                input logic [1:0] s, input logic f, input logic o,
                                input logic eov, input logic [4:0] eod,
                                input logic eir, input logic ese, input logic cod);
        vec_t t;
        t.name = nm; t.rst = r; t.vld = v; t.sel = s; t.flush = f; t.ordy = o;
        t.data = D; t.e_ov = eov; t.e_od = eod; t.e_ir = eir; t.e_se = ese;
        t.chk_od = cod;
        return t;
    endfunction

    task automatic check(input string nm, input logic eov, input logic [4:0] eod,
                         input logic eir, input logic ese, input logic cod);
        n_vec++;
        if (out_valid !== eov || in_ready !== eir || sel_err !== ese ||
            (cod && out_data !== eod)) begin
            n_bad++;
            $display("FAIL %s: got ov=%b od=%0d ir=%b se=%b, want ov=%b od=%0d%s ir=%b se=%b",
                     nm, out_valid, out_data, in_ready, sel_err,
                     eov, eod, cod ? "" : "(x)", eir, ese);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic f, input logic o, input logic [14:0] d);
        rst = r; in_valid = v; in_sel = s; flush = f; out_ready = o; in_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; flush = 1'b0;
        out_ready = 1'b0; in_data = D;

        // reset (overriding flush and a pending transfer)
        vecs.push_back(mk("rst_ovr",   1, 1, 2'd1, 1, 1,  0, 5'd0,  1, 0, 1));
        vecs.push_back(mk("rst",       1, 0, 2'd0, 0, 0,  0, 5'd0,  1, 0, 1));
        // single transfer, one-cycle latency
        vecs.push_back(mk("s1_acc",    0, 1, 2'd1, 0, 1,  1, 5'd15, 1, 0, 1));
        vecs.push_back(mk("s1_pop",    0, 0, 2'd0, 0, 1,  0, 5'd15, 1, 0, 1));
        // fill to FULL with consumer stalled, then drain in order
        vecs.push_back(mk("s2_a0",     0, 1, 2'd0, 0, 0,  1, 5'd7,  1, 0, 1));
        vecs.push_back(mk("s2_a2",     0, 1, 2'd2, 0, 0,  1, 5'd7,  0, 0, 1));
        vecs.push_back(mk("s2_ign",    0, 1, 2'd1, 0, 0,  1, 5'd7,  0, 0, 1));
        vecs.push_back(mk("s2_pop1",   0, 0, 2'd0, 0, 1,  1, 5'd31, 1, 0, 1));
        vecs.push_back(mk("s2_pop2",   0, 0, 2'd0, 0, 1,  0, 5'd31, 1, 0, 1));
        // streaming, no bubbles
        vecs.push_back(mk("st0",       0, 1, 2'd0, 0, 1,  1, 5'd7,  1, 0, 1));
        vecs.push_back(mk("st1",       0, 1, 2'd1, 0, 1,  1, 5'd15, 1, 0, 1));
        vecs.push_back(mk("st2",       0, 1, 2'd2, 0, 1,  1, 5'd31, 1, 0, 1));
        vecs.push_back(mk("st3",       0, 1, 2'd0, 0, 1,  1, 5'd7,  1, 0, 1));
        vecs.push_back(mk("st4",       0, 1, 2'd1, 0, 1,  1, 5'd15, 1, 0, 1));
        vecs.push_back(mk("st5",       0, 1, 2'd2, 0, 1,  1, 5'd31, 1, 0, 1));
        vecs.push_back(mk("st6",       0, 1, 2'd0, 0, 1,  1, 5'd7,  1, 0, 1));
        vecs.push_back(mk("st7",       0, 1, 2'd1, 0, 1,  1, 5'd15, 1, 0, 1));
        vecs.push_back(mk("st_end",    0, 0, 2'd0, 0, 1,  0, 5'd15, 1, 0, 1));
        // bad select: zero data, one pulse per bad accept
        vecs.push_back(mk("bad0",      0, 1, 2'd3, 0, 1,  1, 5'd0,  1, 1, 1));
        vecs.push_back(mk("bad1",      0, 1, 2'd3, 0, 1,  1, 5'd0,  1, 1, 1));
        vecs.push_back(mk("bad_ok",    0, 1, 2'd0, 0, 1,  1, 5'd7,  1, 0, 1));
        vecs.push_back(mk("bad_end",   0, 0, 2'd0, 0, 1,  0, 5'd7,  1, 0, 1));
        // flush from FULL, then flush with a live accept and pop from ONE
        vecs.push_back(mk("fl_a1",     0, 1, 2'd1, 0, 0,  1, 5'd15, 1, 0, 1));
        vecs.push_back(mk("fl_a0",     0, 1, 2'd0, 0, 0,  1, 5'd15, 0, 0, 1));
        vecs.push_back(mk("fl_full",   0, 1, 2'd3, 1, 0,  0, 5'd15, 1, 0, 1));
        vecs.push_back(mk("fl_a2",     0, 1, 2'd2, 0, 0,  1, 5'd31, 1, 0, 1));
        vecs.push_back(mk("fl_one",    0, 1, 2'd3, 1, 1,  0, 5'd31, 1, 0, 1));
        vecs.push_back(mk("fl_idle",   0, 0, 2'd0, 0, 1,  0, 5'd31, 1, 0, 1));
        // reset while FULL
        vecs.push_back(mk("rf_a0",     0, 1, 2'd0, 0, 0,  1, 5'd7,  1, 0, 1));
        vecs.push_back(mk("rf_a1",     0, 1, 2'd1, 0, 0,  1, 5'd7,  0, 0, 1));
        vecs.push_back(mk("rf_rst",    1, 1, 2'd2, 0, 0,  0, 5'd0,  1, 0, 1));
        vecs.push_back(mk("rr_acc",    0, 1, 2'd1, 0, 1,  1, 5'd15, 1, 0, 1));
        vecs.push_back(mk("rr_pop",    0, 0, 2'd0, 0, 1,  0, 5'd15, 1, 0, 1));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].flush,
                 vecs[i].ordy, vecs[i].data);
            check(vecs[i].name, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir,
                  vecs[i].e_se, vecs[i].chk_od);
        end

        // Captured data must not track later in_data; bad select into the skid slot.
        step(0, 1, 2'd0, 0, 0, D);
        check("cap_a0", 1, 5'd7, 1, 0, 1);
        step(0, 1, 2'd3, 0, 0, {5'd1, 5'd2, 5'd3});
        check("cap_bad_full", 1, 5'd7, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 2'd0, 0, 0, {5'd9, 5'd9, 5'd9});
            check("cap_hold", 1, 5'd7, 0, 0, 1);
        end
        step(0, 0, 2'd0, 0, 1, {5'd9, 5'd9, 5'd9});
        check("cap_skid", 1, 5'd0, 1, 0, 1);
        step(0, 0, 2'd0, 0, 1, {5'd9, 5'd9, 5'd9});
        check("cap_empty", 0, 5'd0, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
